// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shared constants for the shift arbiter slice
package shift_arbiter_pkg;
  localparam int DEFAULT_N = 8;
endpackage

// File: rtl/rotr_core.sv
// rotr_core: log-stage N-bit rotate-right, effective amount is amt modulo N
module rotr_core #(
  parameter int N = 8,
  localparam int AW = $clog2(N) + 1
) (
  input  logic [N-1:0]  data,
  input  logic [AW-1:0] amt,
  output logic [N-1:0]  f
);
  localparam int S = $clog2(N);
  logic [S-1:0] sh;
  logic [N-1:0] st [S+1];
  assign sh = S'(amt % AW'(N));
  assign st[0] = data;
  for (genvar s = 0; s < S; s++) begin : g_stage
    assign st[s+1] = sh[s] ? {st[s][2**s-1:0], st[s][N-1:2**s]} : st[s];
  end
  assign f = st[S];
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin two-requester front end to one shared rotate unit with a one-entry result register
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_data,
  input  logic [AW-1:0] req0_amt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_data,
  input  logic [AW-1:0] req1_amt,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_id
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic ptr, grant, accept;
  logic [N-1:0] op_data, rot;
  logic [AW-1:0] op_amt;
  // grant depends only on valids and pointer so readys never see operand data
  always_comb begin
    grant = (req0_valid && req1_valid) ? ptr : req1_valid;
    accept = !reset && (state == EMPTY || rsp_ready) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    op_data = grant ? req1_data : req0_data;
    op_amt = grant ? req1_amt : req0_amt;
  end
  rotr_core #(.N(N)) u_rot (.data(op_data), .amt(op_amt), .f(rot));
  assign rsp_valid = state == FULL;
  // result register: refill on accept, drain on rsp_ready, hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      rsp_data <= '0;
      rsp_id <= 1'b0;
      ptr <= 1'b0;
    end else if (accept) begin
      state <= FULL;
      rsp_data <= rot;
      rsp_id <= grant;
      ptr <= !grant;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: randomized scoreboard bench for shift_arbiter
module tb_shift_arbiter;
  localparam int N = 8;
  localparam int AW = $clog2(N) + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [N-1:0] req0_data = '0, req1_data = '0;
  logic [AW-1:0] req0_amt = '0, req1_amt = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [N-1:0] rsp_data;
  typedef struct packed {logic [N-1:0] d; logic id;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic fav = 1'b0;
  logic held = 1'b0;
  logic prev_stall = 1'b0;
  logic [N-1:0] pd;
  logic pid;

  always #5 clk = ~clk;

  shift_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  function automatic logic [N-1:0] rot(input logic [N-1:0] d, input logic [AW-1:0] a);
    logic [2*N-1:0] t;
    t = {d, d} >> (int'(a) % N);
    return t[N-1:0];
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic v0, input logic [N-1:0] d0, input logic [AW-1:0] a0,
                      input logic v1, input logic [N-1:0] d1, input logic [AW-1:0] a1, input logic rr);
    logic w, acc;
    reset = r; rsp_ready = rr;
    req0_valid = v0; req0_data = d0; req0_amt = a0;
    req1_valid = v1; req1_data = d1; req1_amt = a1;
    #1;
    w = (v0 && v1) ? fav : v1;
    acc = !r && (!held || rr) && (v0 || v1);
    chk("req0_ready", int'(req0_ready), int'(acc && !w));
    chk("req1_ready", int'(req1_ready), int'(acc && w));
    if (r) begin
      q.delete();
      held = 1'b0;
      fav = 1'b0;
    end else if (acc) begin
      q.push_back({rot(w ? d1 : d0, w ? a1 : a0), w});
      fav = !w;
      held = 1'b1;
    end else if (rr) begin
      held = 1'b0;
    end
    @(posedge clk); #2;
    chk("rsp_valid", int'(rsp_valid), int'(held));
    if (r) begin
      chk("reset_rsp_data", int'(rsp_data), 0);
      chk("reset_rsp_id", int'(rsp_id), 0);
    end
  endtask

  // monitor: pops the scoreboard on every delivered result and checks stall stability
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) begin
        chk("stall_valid", int'(rsp_valid), 1);
        chk("stall_data", int'(rsp_data), int'(pd));
        chk("stall_id", int'(rsp_id), int'(pid));
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_data", int'(rsp_data), int'(e.d));
          chk("rsp_id", int'(rsp_id), int'(e.id));
        end
      end
    end
    prev_stall = !reset && rsp_valid && !rsp_ready;
    pd = rsp_data;
    pid = rsp_id;
  end

  initial begin
    @(posedge clk); #2;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8'hB4, 3, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 8'h01, 1, 1);
    step(0, 0, 0, 0, 1, 8'h01, 8, 1);
    step(0, 0, 0, 0, 1, 8'h01, 9, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(0, 1, N'($urandom), AW'($urandom), 1, N'($urandom), AW'($urandom), 1);
    for (int i = 0; i < 4; i++)
      step(0, 1, N'($urandom), AW'($urandom), 1, N'($urandom), AW'($urandom), 0);
    step(0, 1, N'($urandom), AW'($urandom), 1, N'($urandom), AW'($urandom), 1);
    step(0, 1, N'($urandom), AW'($urandom), 1, N'($urandom), AW'($urandom), 0);
    step(1, 1, N'($urandom), AW'($urandom), 1, N'($urandom), AW'($urandom), 0);
    step(0, 1, N'($urandom), AW'($urandom), 1, N'($urandom), AW'($urandom), 1);
    step(0, 1, N'($urandom), AW'($urandom), 1, N'($urandom), AW'($urandom), 1);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom), N'($urandom), AW'($urandom),
           1'($urandom), N'($urandom), AW'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, datapath width in bits; legal values are powers of two, N >= 4.
REQ-002 SHALL derive local constant AW = $clog2(N) + 1, the width of every shift-amount port.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req0_valid, input, 1 bit: requester 0 presents an operation.
REQ-006 SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle when high with req0_valid.
REQ-007 SHALL have port req0_data, input, N bits: requester 0 operand.
REQ-008 SHALL have port req0_amt, input, AW bits: requester 0 rotate-right amount.
REQ-009 SHALL have ports req1_valid, req1_ready, req1_data and req1_amt, identical to the requester 0 ports, for requester 1.
REQ-010 SHALL have port rsp_valid, output, 1 bit: result register holds an undelivered result.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer takes the result when high with rsp_valid.
REQ-012 SHALL have port rsp_data, output, N bits: rotated operand.
REQ-013 SHALL have port rsp_id, output, 1 bit: index of the requester that owns rsp_data.

Function
REQ-014 SHALL share one combinational N-bit rotate-right unit between both requesters; the effective amount is amt modulo N, so amt = N rotates by 0 and amt = N+1 rotates by 1.
REQ-015 SHALL hold a two-state result FSM: EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1).
REQ-016 SHALL compute slot_free = EMPTY, or FULL with rsp_ready = 1 (same-cycle drain and refill).
REQ-017 SHALL grant at most one requester per cycle; reqX_ready = slot_free and grant == X, and a ready is never raised for an invalid requester.
REQ-018 SHALL arbitrate round-robin: with both valid, the requester indicated by the priority pointer wins; with one valid, that requester wins regardless of the pointer.
REQ-019 SHALL toggle the priority pointer to favour the non-winner after every accepted operation; it is unchanged in cycles with no acceptance.
REQ-020 SHALL register the rotated data and the winner index into rsp_data and rsp_id on acceptance; latency is one cycle from the accept edge to rsp_valid = 1.
REQ-021 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without accept; FULL->FULL on accept with rsp_ready; FULL->FULL holding rsp_data and rsp_id stable while rsp_ready = 0.
REQ-022 SHALL sustain one operation per cycle when rsp_ready is held high.
REQ-023 SHALL keep reqX_ready from depending combinationally on reqX_data or reqX_amt; it may depend on the valids, the pointer, the FSM state and rsp_ready.

Reset
REQ-024 SHALL, with reset high at a clock edge, force state EMPTY, rsp_valid = 0, rsp_data = 0, rsp_id = 0 and priority pointer = requester 0.
REQ-025 SHALL drop a pending result when reset is asserted mid-operation, and SHALL accept no request in a cycle where reset is high.
REQ-026 SHALL drive req0_ready = req1_ready = 0 while reset is high.

Structure
REQ-027 SHALL place no typedefs in a package; the FSM state encoding stays local to the module.
REQ-028 SHALL instantiate the rotate unit as a sub-module named rotr_core, with parameter N, ports data, amt[AW-1:0] and f, built as $clog2(N) log-stage rotate-right muxes.

Verification
REQ-029 SHALL cover: N=8, req0 data 0xB4, amt 3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x96, rsp_id=0.
REQ-030 SHALL cover: req1 data 0x01 with amt 1, then amt 8, then amt 9 -> rsp_data 0x80, 0x01 and 0x80 on consecutive cycles, rsp_id=1.
REQ-031 SHALL cover: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 from reset, one result per cycle.
REQ-032 SHALL cover: result in FULL, rsp_ready=0 for 3 cycles -> both readys 0, rsp_data and rsp_id stable; rsp_ready=1 -> drain and refill in the same cycle.
REQ-033 SHALL cover: reset asserted while FULL with both requesters valid -> next cycle rsp_valid=0, rsp_data=0, readys 0, and the first grant after release goes to requester 0.
